// File: rtl/sdram_readback_tx.sv
// sdram_readback_tx: reads one frame from SDRAM word by word and streams it
// out through the JTAG-UART data register, low byte first, gated by UART write space.
module sdram_readback_tx #(
  parameter int WORDS_PER_FRAME = 393216,
  parameter int FRAME_ADDR_BITS = 19
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iTRIGGER,
  input  logic [5:0]  iFRAME_ID,
  input  logic        iWAIT_REQUEST,
  output logic        oRD_EN,
  output logic [24:0] oRD_ADDR,
  input  logic [15:0] iRD_DATA,
  input  logic        iRD_DATAVALID,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT,
  output logic        oBUSY,
  output logic        oDONE
);
  typedef enum logic [2:0] {IDLE, SD_RD, SD_WAIT, POLL, CHK, TX_LO, TX_HI, FIN} state_t;
  state_t r_state, w_next;
  logic [5:0]                 r_frame_id;
  logic [FRAME_ADDR_BITS-1:0] r_word_idx;
  logic [15:0]                r_credit, r_word;
  logic                       r_pend_hi;
  logic                       w_last, w_unused;
  logic [15:0]                w_credit_dec;
  assign w_last       = r_word_idx == FRAME_ADDR_BITS'(WORDS_PER_FRAME - 1);
  assign w_credit_dec = r_credit - 16'd1;
  assign w_unused     = ^iJTAG_SLAVE_RDDATA[15:0];
  assign oRD_EN             = r_state == SD_RD;
  assign oRD_ADDR           = 25'({r_frame_id, r_word_idx});
  assign oJTAG_SLAVE_ADDR   = r_state == POLL;
  assign oJTAG_SLAVE_RDREQ  = r_state == POLL;
  assign oJTAG_SLAVE_WRREQ  = r_state == TX_LO || r_state == TX_HI;
  assign oJTAG_SLAVE_WRDATA = {24'd0, r_state == TX_HI ? r_word[15:8] : r_word[7:0]};
  assign oBUSY              = r_state != IDLE;
  assign oDONE              = r_state == FIN;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iTRIGGER) w_next = SD_RD;
      SD_RD:   if (!iWAIT_REQUEST) w_next = SD_WAIT;
      SD_WAIT: if (iRD_DATAVALID) w_next = r_credit != 16'd0 ? TX_LO : POLL;
      POLL:    if (!iJTAG_SLAVE_WAIT) w_next = CHK;
      CHK:     w_next = r_credit == 16'd0 ? POLL : r_pend_hi ? TX_HI : TX_LO;
      TX_LO:   if (!iJTAG_SLAVE_WAIT) w_next = w_credit_dec != 16'd0 ? TX_HI : POLL;
      TX_HI:   if (!iJTAG_SLAVE_WAIT) w_next = w_last ? FIN : SD_RD;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // r_pend_hi remembers which byte resumes after a credit re-poll
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      r_frame_id <= '0;
      r_word_idx <= '0;
      r_credit   <= '0;
      r_word     <= '0;
      r_pend_hi  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (iTRIGGER) begin
          r_frame_id <= iFRAME_ID;
          r_word_idx <= '0;
          r_credit   <= '0;
          r_pend_hi  <= 1'b0;
        end
        SD_WAIT: if (iRD_DATAVALID) begin
          r_word    <= iRD_DATA;
          r_pend_hi <= 1'b0;
        end
        POLL: if (!iJTAG_SLAVE_WAIT) r_credit <= iJTAG_SLAVE_RDDATA[31:16];
        TX_LO: if (!iJTAG_SLAVE_WAIT) begin
          r_credit  <= w_credit_dec;
          r_pend_hi <= 1'b1;
        end
        TX_HI: if (!iJTAG_SLAVE_WAIT) begin
          r_credit <= w_credit_dec;
          if (!w_last) r_word_idx <= r_word_idx + FRAME_ADDR_BITS'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sdram_readback_tx.sv
// tb_sdram_readback_tx: randomized SDRAM / JTAG-UART responders with a byte-stream
// and credit reference model for the frame readback engine.
module tb_sdram_readback_tx;
  localparam int WPF = 4;
  logic        clk = 1'b0, rst_n;
  logic        iTRIGGER, iWAIT_REQUEST, iRD_DATAVALID, iJTAG_SLAVE_WAIT;
  logic [5:0]  iFRAME_ID;
  logic [15:0] iRD_DATA;
  logic [31:0] iJTAG_SLAVE_RDDATA;
  logic        oRD_EN, oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oBUSY, oDONE;
  logic [24:0] oRD_ADDR;
  logic [31:0] oJTAG_SLAVE_WRDATA;

  sdram_readback_tx #(.WORDS_PER_FRAME(WPF), .FRAME_ADDR_BITS(19)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iTRIGGER(iTRIGGER), .iFRAME_ID(iFRAME_ID),
    .iWAIT_REQUEST(iWAIT_REQUEST), .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR),
    .iRD_DATA(iRD_DATA), .iRD_DATAVALID(iRD_DATAVALID),
    .oJTAG_SLAVE_ADDR(oJTAG_SLAVE_ADDR), .oJTAG_SLAVE_RDREQ(oJTAG_SLAVE_RDREQ),
    .iJTAG_SLAVE_RDDATA(iJTAG_SLAVE_RDDATA), .oJTAG_SLAVE_WRREQ(oJTAG_SLAVE_WRREQ),
    .oJTAG_SLAVE_WRDATA(oJTAG_SLAVE_WRDATA), .iJTAG_SLAVE_WAIT(iJTAG_SLAVE_WAIT),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [15:0] mem [logic [24:0]];
  logic [7:0]  bytes[$];
  logic [24:0] addrs[$];
  int          ws_q[$];
  int ws_def = 64, credit = 0, polls = 0, dones = 0;
  bit rand_wait = 1'b0, pend = 1'b0;
  int lat = 0, stall_left = 0, stall_seen = 0;
  logic [15:0] pend_data;
  logic [24:0] stall_addr;

  // Both responders decide at the falling edge what the DUT sees at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      iWAIT_REQUEST = 1'b0;
      iRD_DATAVALID = 1'b0;
      iJTAG_SLAVE_WAIT = 1'b0;
      ws_q.delete();
      credit = 0;
    end else begin
      iRD_DATAVALID = 1'b0;
      if (pend) begin
        lat--;
        if (lat == 0) begin
          iRD_DATAVALID = 1'b1;
          iRD_DATA = pend_data;
          pend = 1'b0;
        end
      end
      if (oRD_EN) begin
        if (stall_left > 0) begin
          iWAIT_REQUEST = 1'b1;
          if (stall_seen > 0) check("stall_hold", 32'(oRD_ADDR), 32'(stall_addr));
          else stall_addr = oRD_ADDR;
          stall_seen++;
          stall_left--;
        end else begin
          iWAIT_REQUEST = rand_wait && ($urandom % 4 == 0);
          if (stall_seen > 0 && !iWAIT_REQUEST && addrs.size() == 0)
            check("stall_hold", 32'(oRD_ADDR), 32'(stall_addr));
          if (!iWAIT_REQUEST) begin
            check("one_outstanding", 32'(pend), 32'(0));
            addrs.push_back(oRD_ADDR);
            pend = 1'b1;
            lat = $urandom_range(1, 3);
            pend_data = mem.exists(oRD_ADDR) ? mem[oRD_ADDR] : 16'hDEAD;
          end
        end
      end else iWAIT_REQUEST = 1'b0;
      if (!pend && !iRD_DATAVALID && ($urandom % 6 == 0)) begin
        iRD_DATAVALID = 1'b1;
        iRD_DATA = 16'($urandom);
      end
      iJTAG_SLAVE_WAIT = ($urandom % 4 == 0);
      iJTAG_SLAVE_RDDATA = $urandom;
      if (oRD_EN || oJTAG_SLAVE_RDREQ || oJTAG_SLAVE_WRREQ)
        check("req_exclusive", 32'((oRD_EN && (oJTAG_SLAVE_RDREQ || oJTAG_SLAVE_WRREQ)) ||
                                   (oJTAG_SLAVE_RDREQ && oJTAG_SLAVE_WRREQ)), 32'(0));
      if (oJTAG_SLAVE_RDREQ) begin
        check("poll_sel", 32'(oJTAG_SLAVE_ADDR), 32'(1));
        if (!iJTAG_SLAVE_WAIT) begin
          automatic int ws = ws_q.size() > 0 ? ws_q.pop_front() : ws_def;
          iJTAG_SLAVE_RDDATA = {ws[15:0], 16'($urandom)};
          credit = ws;
          polls++;
        end
      end
      if (oJTAG_SLAVE_WRREQ) begin
        check("wr_sel", 32'(oJTAG_SLAVE_ADDR), 32'(0));
        check("wr_upper_zero", 32'(oJTAG_SLAVE_WRDATA[31:8]), 32'(0));
        if (!iJTAG_SLAVE_WAIT) begin
          check("wr_credit", 32'(credit > 0), 32'(1));
          credit--;
          bytes.push_back(oJTAG_SLAVE_WRDATA[7:0]);
        end
      end
      if (oDONE) dones++;
    end
  end

  task automatic fill(input logic [5:0] fid);
    for (int w = 0; w < WPF; w++) mem[{fid, 19'(w)}] = 16'($urandom);
  endtask

  task automatic start(input logic [5:0] fid);
    bytes.delete();
    addrs.delete();
    polls = 0;
    dones = 0;
    iFRAME_ID = fid;
    iTRIGGER = 1'b1;
    @(negedge clk);
    iTRIGGER = 1'b0;
    iFRAME_ID = 6'($urandom);
    check("trig_latency", 32'(oRD_EN), 32'(1));
  endtask

  task automatic wait_bytes(input int n);
    int cyc = 0;
    while (bytes.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("bytes_timeout", 32'(bytes.size() >= n), 32'(1));
  endtask

  task automatic finish_frame(input logic [5:0] fid, input int exp_polls, input bit retrig);
    int cyc = 0;
    bit fired = 1'b0;
    while (dones == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      iTRIGGER = 1'b0;
      if (retrig && !fired && bytes.size() >= 4) begin
        iTRIGGER = 1'b1;
        iFRAME_ID = fid ^ 6'h01;
        fired = 1'b1;
      end
    end
    iTRIGGER = 1'b0;
    check("done_timeout", 32'(dones > 0), 32'(1));
    repeat (4) @(negedge clk);
    check("idle_after", 32'(oBUSY), 32'(0));
    check("done_pulses", 32'(dones), 32'(1));
    check("n_reads", 32'(addrs.size()), 32'(WPF));
    check("n_bytes", 32'(bytes.size()), 32'(2 * WPF));
    for (int w = 0; w < WPF; w++) begin
      logic [24:0] a;
      a = {fid, 19'(w)};
      check("rd_addr", w < addrs.size() ? 32'(addrs[w]) : 32'hFFFF_FFFF, 32'(a));
      check("byte_lo", 2 * w < bytes.size() ? 32'(bytes[2 * w]) : 32'hFFFF_FFFF, 32'(mem[a][7:0]));
      check("byte_hi", 2 * w + 1 < bytes.size() ? 32'(bytes[2 * w + 1]) : 32'hFFFF_FFFF, 32'(mem[a][15:8]));
    end
    if (exp_polls >= 0) check("poll_count", 32'(polls), 32'(exp_polls));
  endtask

  initial begin
    logic [5:0] fid;
    rst_n = 1'b0;
    iTRIGGER = 1'b0;
    iFRAME_ID = '0;
    iWAIT_REQUEST = 1'b0;
    iRD_DATA = '0;
    iRD_DATAVALID = 1'b0;
    iJTAG_SLAVE_WAIT = 1'b0;
    iJTAG_SLAVE_RDDATA = '0;
    for (int w = 0; w < WPF; w++) mem[{6'd3, 19'(w)}] = {8'(2 * w + 2), 8'(2 * w + 1)};
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(oRD_EN), 32'(0));
    check("rst_rd_addr", 32'(oRD_ADDR), 32'(0));
    check("rst_rdreq", 32'(oJTAG_SLAVE_RDREQ), 32'(0));
    check("rst_wrreq", 32'(oJTAG_SLAVE_WRREQ), 32'(0));
    check("rst_jaddr", 32'(oJTAG_SLAVE_ADDR), 32'(0));
    check("rst_wrdata", oJTAG_SLAVE_WRDATA, 32'(0));
    check("rst_busy", 32'(oBUSY), 32'(0));
    check("rst_done", 32'(oDONE), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // basic frame, ample credit: one control read covers all 8 bytes
    ws_def = 64;
    start(6'd3);
    finish_frame(6'd3, 1, 1'b0);
    // first read stalled for 5 cycles
    stall_left = 5;
    stall_seen = 0;
    start(6'd3);
    finish_frame(6'd3, 1, 1'b0);
    check("stall_cycles", 32'(stall_seen), 32'(5));
    stall_seen = 0;
    // UART full three times, then one byte of space per poll
    ws_def = 1;
    ws_q = '{0, 0, 0};
    start(6'd3);
    finish_frame(6'd3, 11, 1'b0);
    // odd credit: every byte needs its own poll
    start(6'd3);
    finish_frame(6'd3, 8, 1'b0);
    // second trigger mid-stream must be ignored
    rand_wait = 1'b1;
    ws_def = 3;
    fill(6'd2);
    start(6'd3);
    finish_frame(6'd3, -1, 1'b1);
    // asynchronous reset mid-frame, then a clean restart
    fid = 6'd21;
    fill(fid);
    start(fid);
    wait_bytes(2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rd_en", 32'(oRD_EN), 32'(0));
    check("abort_rdreq", 32'(oJTAG_SLAVE_RDREQ), 32'(0));
    check("abort_wrreq", 32'(oJTAG_SLAVE_WRREQ), 32'(0));
    check("abort_busy", 32'(oBUSY), 32'(0));
    check("abort_rd_addr", 32'(oRD_ADDR), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", 32'(oBUSY), 32'(0));
    start(fid);
    finish_frame(fid, -1, 1'b0);
    // randomized frames, credits and stalls
    for (int t = 0; t < 6; t++) begin
      fid = 6'($urandom);
      fill(fid);
      ws_def = $urandom_range(1, 6);
      for (int k = $urandom_range(0, 2); k > 0; k--) ws_q.push_back(0);
      start(fid);
      finish_frame(fid, -1, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
